// File: rtl/axis_gen_pkg.sv
// Shared types and payload helper for the AXI-Stream frame generator.
package axis_gen_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } gen_state_t;

   // Byte k of beat b in frame f: seed + f + b*keep_width + k, all modulo 256.
   function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [7:0] f,
                                               input logic [7:0] b, input logic [7:0] k,
                                               input int unsigned keep_width);
      logic [7:0]  kw;
      logic [15:0] boff;
      kw   = 8'(keep_width);
      boff = {8'h00, b} * {8'h00, kw};
      return seed + f + boff[7:0] + k;
   endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI-Stream bundle between the frame generator and its sink.
interface axis_frame_gen_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned DEST_WIDTH = 8,
   parameter int unsigned USER_WIDTH = 1
);

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;
   logic [DEST_WIDTH-1:0] tdest;
   logic [USER_WIDTH-1:0] tuser;

   modport master (
      output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
      output tready
   );

endinterface

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame transmitter: configurable length, gap, frame count and bad-frame marking.
module axis_frame_gen
   import axis_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned DEST_WIDTH = 8,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic [LEN_WIDTH-1:0]  cfg_gap,
   input  logic [CNT_WIDTH-1:0]  cfg_frames,
   input  logic [7:0]            cfg_seed,
   input  logic [ID_WIDTH-1:0]   cfg_id,
   input  logic [DEST_WIDTH-1:0] cfg_dest,
   input  logic                  cfg_bad,
   axis_frame_gen_if.master      m_axis,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   gen_state_t            state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, gap_q, b_q, b_d, gap_cnt_q, gap_cnt_d;
   logic [CNT_WIDTH-1:0]  frames_q, fc_q, fc_d;
   logic [7:0]            seed_q;
   logic                  bad_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [DEST_WIDTH-1:0] dest_q;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_q;
   logic [USER_WIDTH-1:0] tuser_q, tuser_d;
   logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                  busy_q, done_q, done_d;

   logic [LEN_WIDTH-1:0]  len_eff, b_inc;
   logic [CNT_WIDTH-1:0]  fc_inc;
   logic                  latch, load, clear, ld_last, ld_bad;
   logic [7:0]            ld_seed, ld_f, ld_b;
   logic [DATA_WIDTH-1:0] beat_data;

   assign len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
   assign b_inc   = b_q + LEN_WIDTH'(1);
   assign fc_inc  = fc_q + CNT_WIDTH'(1);

   // Payload for the beat about to be loaded, one byte lane per iteration.
   for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_byte
      assign beat_data[8*k +: 8] = pattern_byte(ld_seed, ld_f, ld_b, 8'(k), KEEP_WIDTH);
   end

   // Next-state logic: frame sequencing, end-of-run detection and beat load selection.
   always_comb begin
      state_d   = state_q;
      b_d       = b_q;
      gap_cnt_d = gap_cnt_q;
      fc_d      = fc_q;
      latch     = 1'b0;
      load      = 1'b0;
      clear     = 1'b0;
      done_d    = 1'b0;
      ld_seed   = seed_q;
      ld_f      = 8'(fc_q);
      ld_b      = 8'h00;
      ld_last   = 1'b0;
      ld_bad    = bad_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               latch   = 1'b1;
               state_d = StSend;
               fc_d    = '0;
               b_d     = '0;
               load    = 1'b1;
               ld_seed = cfg_seed;
               ld_f    = 8'h00;
               ld_last = (len_eff == LEN_WIDTH'(1));
               ld_bad  = cfg_bad;
            end
         end
         StSend: begin
            if (tvalid_q && m_axis.tready) begin
               if (tlast_q) begin
                  fc_d = fc_inc;
                  b_d  = '0;
                  if (stop || (frames_q != '0 && fc_inc == frames_q)) begin
                     state_d = StIdle;
                     clear   = 1'b1;
                     done_d  = 1'b1;
                  end else if (gap_q != '0) begin
                     state_d   = StGap;
                     gap_cnt_d = gap_q;
                     clear     = 1'b1;
                  end else begin
                     load    = 1'b1;
                     ld_f    = 8'(fc_inc);
                     ld_last = (len_q == LEN_WIDTH'(1));
                  end
               end else begin
                  b_d     = b_inc;
                  load    = 1'b1;
                  ld_b    = 8'(b_inc);
                  ld_last = (b_inc == len_q - LEN_WIDTH'(1));
               end
            end
         end
         StGap: begin
            if (stop) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (gap_cnt_q == LEN_WIDTH'(1)) begin
               state_d = StSend;
               load    = 1'b1;
               ld_last = (len_q == LEN_WIDTH'(1));
            end else begin
               gap_cnt_d = gap_cnt_q - LEN_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Beat register next values: load a fresh beat or retire the bus; otherwise hold.
   always_comb begin
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      if (load) begin
         tvalid_d = 1'b1;
         tdata_d  = beat_data;
         tlast_d  = ld_last;
         tuser_d  = (ld_last && ld_bad) ? '1 : '0;
      end else if (clear) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         tuser_d  = '0;
      end
   end

   // All state and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         len_q     <= '0;
         gap_q     <= '0;
         frames_q  <= '0;
         seed_q    <= '0;
         bad_q     <= 1'b0;
         id_q      <= '0;
         dest_q    <= '0;
         tkeep_q   <= '0;
         b_q       <= '0;
         gap_cnt_q <= '0;
         fc_q      <= '0;
         tvalid_q  <= 1'b0;
         tdata_q   <= '0;
         tlast_q   <= 1'b0;
         tuser_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (latch) begin
            len_q    <= len_eff;
            gap_q    <= cfg_gap;
            frames_q <= cfg_frames;
            seed_q   <= cfg_seed;
            bad_q    <= cfg_bad;
            id_q     <= cfg_id;
            dest_q   <= cfg_dest;
            tkeep_q  <= '1;
         end
         state_q   <= state_d;
         b_q       <= b_d;
         gap_cnt_q <= gap_cnt_d;
         fc_q      <= fc_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
         tlast_q   <= tlast_d;
         tuser_q   <= tuser_d;
         busy_q    <= (state_d != StIdle);
         done_q    <= done_d;
      end
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = tkeep_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tid    = id_q;
   assign m_axis.tdest  = dest_q;
   assign m_axis.tuser  = tuser_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign frame_count   = fc_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: table of runs, random runs, reset corner cases.
module tb_axis_frame_gen;

   localparam int unsigned DW  = 16;
   localparam int unsigned KW  = 2;
   localparam int unsigned IW  = 8;
   localparam int unsigned DSW = 8;
   localparam int unsigned UW  = 2;
   localparam int unsigned LW  = 16;
   localparam int unsigned CW  = 16;
   localparam int PH_SEND = 0;
   localparam int PH_GAP  = 1;
   localparam int PH_END  = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           stop = 1'b0;
   logic [LW-1:0]  cfg_len = '0;
   logic [LW-1:0]  cfg_gap = '0;
   logic [CW-1:0]  cfg_frames = '0;
   logic [7:0]     cfg_seed = '0;
   logic [IW-1:0]  cfg_id = '0;
   logic [DSW-1:0] cfg_dest = '0;
   logic           cfg_bad = 1'b0;
   logic           busy;
   logic           done;
   logic [CW-1:0]  frame_count;

   int checks = 0;
   int failures = 0;

   axis_frame_gen_if #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
   ) m_axis_if ();

   axis_frame_gen #(
      .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW),
      .LEN_WIDTH(LW), .CNT_WIDTH(CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .cfg_len    (cfg_len),
      .cfg_gap    (cfg_gap),
      .cfg_frames (cfg_frames),
      .cfg_seed   (cfg_seed),
      .cfg_id     (cfg_id),
      .cfg_dest   (cfg_dest),
      .cfg_bad    (cfg_bad),
      .m_axis     (m_axis_if),
      .busy       (busy),
      .done       (done),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int gap;
      int frames;
      int seed;
      int bad;
      int ready_pct;
      int stop_beat;
      int exp_frames;
      int exp_beats;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference payload straight from the byte formula.
   function automatic logic [DW-1:0] exp_data(input int seed, input int f, input int b);
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < int'(KW); k++) d[8*k +: 8] = 8'((seed + f + b * int'(KW) + k) % 256);
      return d;
   endfunction

   // One run: start, then per cycle predict the bus from the frame rules and compare.
   task automatic run_case(input int len, input int gap, input int frames, input int seed,
                           input int bad, input int ready_pct, input int stop_beat,
                           input int exp_frames, input int exp_beats);
      int             elen, mf, mb, gap_left, total, cyc, phase;
      bit             first, running;
      logic           pv, pr, ps, lst;
      logic [IW-1:0]  id;
      logic [DSW-1:0] dest;
      elen = (len == 0) ? 1 : len;
      id   = IW'($urandom);
      dest = DSW'($urandom);
      @(negedge clk);
      cfg_len    = LW'(len);
      cfg_gap    = LW'(gap);
      cfg_frames = CW'(frames);
      cfg_seed   = 8'(seed);
      cfg_bad    = (bad != 0);
      cfg_id     = id;
      cfg_dest   = dest;
      start      = 1'b1;
      stop       = 1'b0;
      m_axis_if.tready = ($urandom_range(0, 99) < ready_pct);
      pv = 1'b0; pr = m_axis_if.tready; ps = 1'b0;
      mf = 0; mb = 0; gap_left = 0; total = 0; cyc = 0; phase = PH_SEND;
      first = 1'b1; running = 1'b1;
      while (running) begin
         @(negedge clk);
         if (!first) begin
            if (phase == PH_SEND) begin
               if (pv && pr) begin
                  total++;
                  if (mb == elen - 1) begin
                     mf++;
                     mb = 0;
                     if (ps || (frames != 0 && mf == frames)) phase = PH_END;
                     else if (gap != 0) begin
                        phase = PH_GAP;
                        gap_left = gap;
                     end
                  end else begin
                     mb++;
                  end
               end
            end else if (phase == PH_GAP) begin
               if (ps) phase = PH_END;
               else begin
                  gap_left--;
                  if (gap_left == 0) phase = PH_SEND;
               end
            end
         end
         first = 1'b0;
         chk("frame_count", frame_count, 64'(CW'(mf)));
         if (phase == PH_SEND) begin
            lst = (mb == elen - 1);
            chk("tvalid", m_axis_if.tvalid, 1);
            chk("tdata", m_axis_if.tdata, exp_data(seed, mf, mb));
            chk("tlast", m_axis_if.tlast, lst);
            chk("tuser", m_axis_if.tuser, (lst && bad != 0) ? {UW{1'b1}} : {UW{1'b0}});
            chk("tkeep", m_axis_if.tkeep, {KW{1'b1}});
            chk("tid", m_axis_if.tid, id);
            chk("tdest", m_axis_if.tdest, dest);
            chk("busy", busy, 1);
            chk("done_low", done, 0);
         end else if (phase == PH_GAP) begin
            chk("gap_tvalid", m_axis_if.tvalid, 0);
            chk("gap_busy", busy, 1);
            chk("done_low", done, 0);
         end else begin
            chk("done_pulse", done, 1);
            chk("end_busy", busy, 0);
            chk("end_tvalid", m_axis_if.tvalid, 0);
            chk("end_frames", frame_count, 64'(exp_frames));
            chk("end_beats", 64'(total), 64'(exp_beats));
            start = 1'b0;
            stop  = 1'b0;
            @(negedge clk);
            chk("done_once", done, 0);
            chk("idle_busy", busy, 0);
            running = 1'b0;
         end
         if (running) begin
            pv         = m_axis_if.tvalid;
            start      = 1'($urandom_range(0, 1));
            cfg_len    = LW'($urandom);
            cfg_gap    = LW'($urandom);
            cfg_frames = CW'($urandom);
            cfg_seed   = 8'($urandom);
            cfg_id     = IW'($urandom);
            cfg_dest   = DSW'($urandom);
            cfg_bad    = 1'($urandom_range(0, 1));
            m_axis_if.tready = ($urandom_range(0, 99) < ready_pct);
            stop       = (stop_beat != 0 && total >= stop_beat);
            pr = m_axis_if.tready;
            ps = stop;
            cyc++;
            if (cyc > 3000) begin
               checks++;
               failures++;
               $display("FAIL run_timeout got=%0d cycles exp=done", cyc);
               start = 1'b0;
               stop  = 1'b0;
               rst_n = 1'b0;
               @(negedge clk);
               rst_n = 1'b1;
               running = 1'b0;
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, gap, frames;
      //           len gap frm seed  bad rdy stopb expf expb
      vecs[0] = '{4, 0, 1, 'h10, 0, 100, 0, 1, 4};
      vecs[1] = '{3, 2, 2, 'h10, 1, 100, 0, 2, 6};
      vecs[2] = '{5, 1, 3, 'h33, 0, 50, 0, 3, 15};
      vecs[3] = '{4, 0, 0, 'h00, 0, 80, 10, 3, 12};
      vecs[4] = '{0, 0, 3, 'hFF, 0, 100, 0, 3, 3};
      vecs[5] = '{2, 3, 0, 'h7E, 1, 70, 4, 2, 4};
      vecs[6] = '{1, 0, 0, 'hF0, 1, 60, 5, 6, 6};

      m_axis_if.tready = 1'b0;
      #1;
      chk("rst_tvalid", m_axis_if.tvalid, 0);
      chk("rst_tlast", m_axis_if.tlast, 0);
      chk("rst_tuser", m_axis_if.tuser, 0);
      chk("rst_tdata", m_axis_if.tdata, 0);
      chk("rst_tkeep", m_axis_if.tkeep, 0);
      chk("rst_tid", m_axis_if.tid, 0);
      chk("rst_tdest", m_axis_if.tdest, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_frame_count", frame_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_case(vecs[i].len, vecs[i].gap, vecs[i].frames, vecs[i].seed, vecs[i].bad,
                  vecs[i].ready_pct, vecs[i].stop_beat, vecs[i].exp_frames, vecs[i].exp_beats);
      end

      for (int i = 0; i < 8; i++) begin
         len    = $urandom_range(0, 6);
         gap    = $urandom_range(0, 3);
         frames = $urandom_range(1, 4);
         run_case(len, gap, frames, int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                  int'($urandom_range(30, 100)), 0, frames, frames * ((len == 0) ? 1 : len));
      end

      // Asynchronous reset while beat 2 of a frame is on the bus.
      @(negedge clk);
      cfg_len = 4; cfg_gap = 0; cfg_frames = 1; cfg_seed = 8'h20; cfg_bad = 1'b0;
      cfg_id = 8'h5A; cfg_dest = 8'hA5;
      start = 1'b1;
      m_axis_if.tready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_tdata", m_axis_if.tdata, exp_data('h20, 0, 2));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", m_axis_if.tvalid, 0);
      chk("arst_tdata", m_axis_if.tdata, 0);
      chk("arst_tlast", m_axis_if.tlast, 0);
      chk("arst_tkeep", m_axis_if.tkeep, 0);
      chk("arst_tid", m_axis_if.tid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_frame_count", frame_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", busy, 0);
      run_case(4, 0, 1, 'h20, 0, 100, 0, 1, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
